// File: rtl/bidir_bus_pkg.sv
// bidir_bus_pkg: shared state encoding, bus width default and parameter checks
// for the bidirectional harness bus controller.
package bidir_bus_pkg;
   localparam int BUS_WIDTH = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DRIVE = 3'd1,
      ST_TURN  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic bit params_legal(input int drive, input int turn, input int sample);
      return (drive >= 1) && (turn >= 0) && (sample >= 1);
   endfunction
endpackage

// File: rtl/bidir_bus_ctrl.sv
// bidir_bus_ctrl: sequences single reads/writes on split bus signals with
// drive-hold and turnaround timing; the pad stage owns the actual tristate.
module bidir_bus_ctrl
   import bidir_bus_pkg::*;
#(
   parameter int WIDTH        = BUS_WIDTH,
   parameter int DRIVE_CYCLES = 2,
   parameter int TURN_CYCLES  = 1,
   parameter int SAMPLE_DELAY = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_write,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic [WIDTH-1:0] bus_out,
   output logic             bus_oe,
   input  logic [WIDTH-1:0] bus_in
);
   localparam int CW = $clog2(max3(DRIVE_CYCLES, TURN_CYCLES, SAMPLE_DELAY)) + 1;

   if (!params_legal(DRIVE_CYCLES, TURN_CYCLES, SAMPLE_DELAY)) begin : g_bad_params
      $error("bidir_bus_ctrl: illegal timing parameters");
   end

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_bus_oe;
   logic [WIDTH-1:0] r_bus_out;
   logic             r_rsp_valid;
   logic             r_rsp_write;
   logic [WIDTH-1:0] r_rsp_rdata;
   logic             w_last;

   assign w_last    = r_cnt == CW'(1);
   assign req_ready = r_state == ST_IDLE;
   assign bus_oe    = r_bus_oe;
   assign bus_out   = r_bus_out;
   assign rsp_valid = r_rsp_valid;
   assign rsp_write = r_rsp_write;
   assign rsp_rdata = r_rsp_rdata;

   // Write data is parked in r_rsp_rdata at accept, so the echo needs no extra latch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_bus_oe    <= 1'b0;
         r_bus_out   <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (req_valid) begin
               r_rsp_write <= req_write;
               if (req_write) begin
                  r_state     <= ST_DRIVE;
                  r_cnt       <= CW'(DRIVE_CYCLES);
                  r_bus_oe    <= 1'b1;
                  r_bus_out   <= req_wdata;
                  r_rsp_rdata <= req_wdata;
               end else begin
                  r_state <= ST_WAIT;
                  r_cnt   <= CW'(SAMPLE_DELAY);
               end
            end
            ST_DRIVE: if (w_last) begin
               r_bus_oe  <= 1'b0;
               r_bus_out <= '0;
               if (TURN_CYCLES == 0) begin
                  r_state     <= ST_RESP;
                  r_cnt       <= '0;
                  r_rsp_valid <= 1'b1;
               end else begin
                  r_state <= ST_TURN;
                  r_cnt   <= CW'(TURN_CYCLES);
               end
            end else r_cnt <= r_cnt - CW'(1);
            ST_TURN: if (w_last) begin
               r_state     <= ST_RESP;
               r_cnt       <= '0;
               r_rsp_valid <= 1'b1;
            end else r_cnt <= r_cnt - CW'(1);
            ST_WAIT: if (w_last) begin
               r_state     <= ST_RESP;
               r_cnt       <= '0;
               r_rsp_valid <= 1'b1;
               r_rsp_rdata <= bus_in;
            end else r_cnt <= r_cnt - CW'(1);
            ST_RESP: if (rsp_ready) begin
               r_state     <= ST_IDLE;
               r_cnt       <= '0;
               r_rsp_valid <= 1'b0;
            end
            default: begin
               r_state  <= ST_IDLE;
               r_cnt    <= '0;
               r_bus_oe <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// tb_bidir_bus_ctrl: directed and random transactions on two controller
// configurations, checked against a timeline model of each transaction.
module tb_bidir_bus_ctrl;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         sel = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_write = 1'b0;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] req_wdata = '0;
   logic [W-1:0] bus_in = '0;
   int           checks = 0;
   int           errors = 0;

   logic         a_req_ready, a_rsp_valid, a_rsp_write, a_bus_oe;
   logic [W-1:0] a_rsp_rdata, a_bus_out;
   logic         b_req_ready, b_rsp_valid, b_rsp_write, b_bus_oe;
   logic [W-1:0] b_rsp_rdata, b_bus_out;
   logic         m_req_ready, m_rsp_valid, m_rsp_write, m_bus_oe;
   logic [W-1:0] m_rsp_rdata, m_bus_out;

   always #5 clk = ~clk;

   bidir_bus_ctrl dut_a (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid && !sel), .req_ready(a_req_ready),
      .req_write(req_write), .req_wdata(req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready && !sel),
      .rsp_write(a_rsp_write), .rsp_rdata(a_rsp_rdata),
      .bus_out(a_bus_out), .bus_oe(a_bus_oe), .bus_in(bus_in)
   );

   bidir_bus_ctrl #(.DRIVE_CYCLES(1), .TURN_CYCLES(0), .SAMPLE_DELAY(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid && sel), .req_ready(b_req_ready),
      .req_write(req_write), .req_wdata(req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready && sel),
      .rsp_write(b_rsp_write), .rsp_rdata(b_rsp_rdata),
      .bus_out(b_bus_out), .bus_oe(b_bus_oe), .bus_in(bus_in)
   );

   assign m_req_ready = sel ? b_req_ready : a_req_ready;
   assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
   assign m_rsp_write = sel ? b_rsp_write : a_rsp_write;
   assign m_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
   assign m_bus_out   = sel ? b_bus_out   : a_bus_out;
   assign m_bus_oe    = sel ? b_bus_oe    : a_bus_oe;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // A transaction is a fixed timeline after the accept edge: drive window,
   // dead window, then the response, whose data must survive a stalled rsp_ready.
   task automatic txn(input bit wr, input logic [W-1:0] wd, input logic [W-1:0] bin,
                      input int hold, input logic [W-1:0] hold_in);
      int d, t, s, lat;
      logic [W-1:0] exp_data;
      d = sel ? 1 : 2;
      t = sel ? 0 : 1;
      s = 1;
      lat = wr ? d + t : s;
      exp_data = wr ? wd : bin;
      chk("idle_req_ready", m_req_ready, 1);
      req_valid = 1'b1;
      req_write = wr;
      req_wdata = wd;
      bus_in = bin;
      step();
      req_valid = 1'b0;
      req_wdata = W'($urandom);
      for (int k = 0; k < lat; k++) begin
         chk("busy_bus_oe", m_bus_oe, (wr && k < d) ? 1 : 0);
         chk("busy_bus_out", m_bus_out, (wr && k < d) ? wd : '0);
         chk("busy_rsp_valid", m_rsp_valid, 0);
         chk("busy_req_ready", m_req_ready, 0);
         step();
      end
      chk("rsp_valid", m_rsp_valid, 1);
      chk("rsp_write", m_rsp_write, wr);
      chk("rsp_rdata", m_rsp_rdata, exp_data);
      chk("rsp_bus_oe", m_bus_oe, 0);
      bus_in = hold_in;
      for (int h = 0; h < hold; h++) begin
         step();
         chk("hold_rsp_valid", m_rsp_valid, 1);
         chk("hold_rsp_rdata", m_rsp_rdata, exp_data);
         chk("hold_req_ready", m_req_ready, 0);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("done_rsp_valid", m_rsp_valid, 0);
      chk("done_req_ready", m_req_ready, 1);
   endtask

   initial begin
      step();
      step();
      chk("rst_bus_oe", a_bus_oe, 0);
      chk("rst_bus_out", a_bus_out, 0);
      chk("rst_rsp_valid", a_rsp_valid, 0);
      chk("rst_rsp_write", a_rsp_write, 0);
      chk("rst_rsp_rdata", a_rsp_rdata, 0);
      chk("rst_b_bus_oe", b_bus_oe, 0);
      rst_n = 1'b1;
      step();
      chk("rst_req_ready", a_req_ready, 1);

      txn(1'b1, 16'd13333, 16'h0, 0, 16'h0);
      txn(1'b0, 16'h0, 16'd3333, 0, 16'h0);
      txn(1'b0, 16'h0, 16'd3333, 5, 16'd7);
      txn(1'b1, 16'hFFFF, 16'h0, 1, 16'h0);
      txn(1'b0, 16'h0, 16'h1234, 0, 16'h0);

      req_valid = 1'b1;
      req_write = 1'b1;
      req_wdata = 16'd13333;
      step();
      req_valid = 1'b0;
      step();
      chk("mid_drive_bus_oe", a_bus_oe, 1);
      rst_n = 1'b0;
      step();
      chk("abort_bus_oe", a_bus_oe, 0);
      chk("abort_bus_out", a_bus_out, 0);
      chk("abort_rsp_valid", a_rsp_valid, 0);
      rst_n = 1'b1;
      chk("abort_req_ready", a_req_ready, 1);
      step();
      chk("abort_no_rsp", a_rsp_valid, 0);

      sel = 1'b1;
      txn(1'b1, 16'd42, 16'h0, 0, 16'h0);
      txn(1'b0, 16'h0, 16'hBEEF, 2, 16'h5A5A);

      for (int i = 0; i < 24; i++) begin
         sel = 1'($urandom_range(0, 1));
         txn(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
             $urandom_range(0, 3), W'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
